// File: rtl/tile_mem_arbiter.sv
// Round-robin arbiter sharing the tile's single-port BRAM between the AXI indirect path and the core bus.
// One access in flight at a time; the WAIT state covers the BRAM read latency.
module tile_mem_arbiter #(
    parameter int unsigned BW     = 32,
    parameter int unsigned BWB    = BW / 8,
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_line,
    input  logic              clk_line_rst_high,
    input  logic              axi_mem_valid,
    input  logic [31:0]       axi_mem_addr,
    input  logic [BW-1:0]     axi_mem_wdata,
    input  logic              axi_mem_we,
    output logic              axi_mem_ready,
    output logic [BW-1:0]     axi_mem_rdata,
    input  logic              cpu_mem_valid,
    input  logic [31:0]       cpu_mem_addr,
    input  logic [BW-1:0]     cpu_mem_wdata,
    input  logic [BWB-1:0]    cpu_mem_wstrb,
    output logic              cpu_mem_ready,
    output logic [BW-1:0]     cpu_mem_rdata,
    output logic              bram_en,
    output logic [BWB-1:0]    bram_we,
    output logic [MEM_AW-1:0] bram_addr,
    output logic [BW-1:0]     bram_din,
    input  logic [BW-1:0]     bram_dout,
    output logic [CNT_W-1:0]  axi_grant_cnt,
    output logic [CNT_W-1:0]  cpu_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    wait_q, wait_d;
    logic                grant_cpu_q, grant_cpu_d;
    logic                in_range_q, in_range_d;
    logic                last_cpu_q, last_cpu_d;

    logic                pick_cpu;
    logic [31:0]         sel_addr;
    logic                sel_in_range;
    logic                conflict_inc;
    logic                en_d;
    logic [BWB-1:0]      we_d;
    logic [MEM_AW-1:0]   addr_d;
    logic [BW-1:0]       din_d;
    logic                capture;
    logic                resp_d;

    // State register
    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, arbitration and next values of the registered BRAM/response outputs
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        grant_cpu_d  = grant_cpu_q;
        in_range_d   = in_range_q;
        last_cpu_d   = last_cpu_q;
        conflict_inc = 1'b0;
        en_d         = 1'b0;
        we_d         = '0;
        addr_d       = bram_addr;
        din_d        = bram_din;
        capture      = 1'b0;
        resp_d       = 1'b0;

        // On a tie the requester that did not win last time goes first
        pick_cpu     = cpu_mem_valid && (!axi_mem_valid || !last_cpu_q);
        sel_addr     = pick_cpu ? cpu_mem_addr : axi_mem_addr;
        sel_in_range = (sel_addr >> (MEM_AW + 2)) == 32'd0;

        case (state_q)
            IDLE: begin
                if (axi_mem_valid || cpu_mem_valid) begin
                    state_d      = ISSUE;
                    wait_d       = '0;
                    grant_cpu_d  = pick_cpu;
                    last_cpu_d   = pick_cpu;
                    in_range_d   = sel_in_range;
                    conflict_inc = axi_mem_valid && cpu_mem_valid;
                    en_d         = sel_in_range;
                    if (sel_in_range) begin
                        we_d = pick_cpu ? cpu_mem_wstrb : {BWB{axi_mem_we}};
                    end
                    addr_d       = sel_addr[MEM_AW+1:2];
                    din_d        = pick_cpu ? cpu_mem_wdata : axi_mem_wdata;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == LAT_W'(RD_LAT - 1)) begin
                    state_d = RESP;
                    capture = 1'b1;
                    resp_d  = 1'b1;
                end else begin
                    wait_d = wait_q + LAT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered datapath, responses and saturating diagnostics
    always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
        if (clk_line_rst_high) begin
            wait_q        <= '0;
            grant_cpu_q   <= 1'b0;
            in_range_q    <= 1'b0;
            last_cpu_q    <= 1'b1;
            bram_en       <= 1'b0;
            bram_we       <= '0;
            bram_addr     <= '0;
            bram_din      <= '0;
            axi_mem_ready <= 1'b0;
            cpu_mem_ready <= 1'b0;
            axi_mem_rdata <= '0;
            cpu_mem_rdata <= '0;
            axi_grant_cnt <= '0;
            cpu_grant_cnt <= '0;
            conflict_cnt  <= '0;
        end else begin
            wait_q        <= wait_d;
            grant_cpu_q   <= grant_cpu_d;
            in_range_q    <= in_range_d;
            last_cpu_q    <= last_cpu_d;
            bram_en       <= en_d;
            bram_we       <= we_d;
            bram_addr     <= addr_d;
            bram_din      <= din_d;
            axi_mem_ready <= resp_d && !grant_cpu_q;
            cpu_mem_ready <= resp_d && grant_cpu_q;

            // Out-of-range accesses never enabled the BRAM, so they read back as zero
            if (capture && !grant_cpu_q) begin
                axi_mem_rdata <= in_range_q ? bram_dout : '0;
            end
            if (capture && grant_cpu_q) begin
                cpu_mem_rdata <= in_range_q ? bram_dout : '0;
            end

            if (state_q == RESP) begin
                if (grant_cpu_q) begin
                    if (cpu_grant_cnt != '1) cpu_grant_cnt <= cpu_grant_cnt + CNT_W'(1);
                end else begin
                    if (axi_grant_cnt != '1) axi_grant_cnt <= axi_grant_cnt + CNT_W'(1);
                end
            end
            if (conflict_inc && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/tile_mem_arbiter.md
# tile_mem_arbiter

Two-port arbiter that shares the tile's single-port instruction/data BRAM between the AXI-Lite indirect memory path (host loads and readback) and the tile's RISC-V core memory bus. It sits in the `clk_line` domain between the AXI indirect-access block's memory outputs (after CDC), the core, and the BRAM. It grants one access at a time with round-robin fairness, sequences the BRAM read latency, and returns per-requester ready/rdata. It also keeps saturating grant and conflict counters that the host reads as diagnostics.

## Interface
- `BW`, 32, data width.
- `BWB`, `BW/8`, byte-strobe width.
- `MEM_AW`, 12, BRAM word-address width; byte address space is `4<<MEM_AW`.
- `RD_LAT`, 1, BRAM read latency in cycles (>=1).
- `CNT_W`, 16, diagnostic counter width.
- `clk_line` in 1: the only clock.
- `clk_line_rst_high` in 1: reset, asynchronous, active-high.
- `axi_mem_valid` in 1: AXI-path request; held until `axi_mem_ready`.
- `axi_mem_addr` in 32: byte address.
- `axi_mem_wdata` in BW: write data.
- `axi_mem_we` in 1: 1 means a full-word write, 0 means a read.
- `axi_mem_ready` out 1: one-cycle completion pulse.
- `axi_mem_rdata` out BW: read data, valid while `axi_mem_ready` is high.
- `cpu_mem_valid`, `cpu_mem_addr`, `cpu_mem_wdata`: in 1/32/BW, same rules as the AXI path.
- `cpu_mem_wstrb` in BWB: byte write strobes; all zero means a read.
- `cpu_mem_ready` out 1, `cpu_mem_rdata` out BW: same rules as the AXI path.
- `bram_en` out 1: BRAM enable.
- `bram_we` out BWB: BRAM byte write enables.
- `bram_addr` out MEM_AW: BRAM word address.
- `bram_din` out BW: BRAM write data.
- `bram_dout` in BW: BRAM read data, `RD_LAT` cycles after `bram_en`.
- `axi_grant_cnt`, `cpu_grant_cnt`, `conflict_cnt` out CNT_W each: saturating counters.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE to ISSUE when either valid is high.
  - ISSUE to WAIT unconditionally.
  - WAIT holds for `RD_LAT` cycles, then goes to RESP.
  - RESP to IDLE unconditionally.
- Arbitration happens only in IDLE.
  - A single valid requester wins.
  - If both are valid, the winner is the requester that is not `last_grant`, and `conflict_cnt` increments.
  - `last_grant` resets to CPU, so the AXI path wins the first tie.
- The winner's address, wdata, and write enables are latched at the IDLE-to-ISSUE edge. Requester inputs are ignored from then until the next IDLE.
- ISSUE drives registered BRAM outputs for one cycle:
  - `bram_en`=1.
  - `bram_addr`=`addr[MEM_AW+1:2]`.
  - `bram_din`=wdata.
  - `bram_we` is `{BWB{axi_mem_we}}` for an AXI grant, or `cpu_mem_wstrb` for a CPU grant.
- Out-of-range access (any of `addr[31:MEM_AW+2]` nonzero):
  - `bram_en` stays 0 in ISSUE.
  - Reads return 0; writes are dropped.
  - The ready pulse still occurs with normal timing.
- `addr[1:0]` is ignored.
- On the last WAIT cycle, `bram_dout` is captured into the winner's rdata register. Writes also capture, and the value is don't-care.
- In RESP, the winner's ready=1 for exactly one cycle, and the winner's grant counter increments.
- Counters saturate at all-ones.
- In the RESP cycle, valid may still be high. The requester must drop valid by the next IDLE.

## Timing
- Reset values: all readys 0, both rdata 0, `bram_en`=0, `bram_we`=0, `bram_addr`=0, `bram_din`=0, counters 0, state IDLE, `last_grant`=CPU.
- An async reset mid-transaction aborts immediately. The BRAM write completes only if the ISSUE edge already occurred.
- Latency: valid sampled in cycle C, `bram_en` in C+1, ready in C+2+`RD_LAT` (C+3 for default).
- Throughput: one access per `RD_LAT`+3 cycles. The loser of a tie waits one full transaction.

## Test plan
- AXI write 0xA5A5_0001 to 0x10, then AXI read 0x10 -> `bram_we`=4'hF, `bram_addr`=4; read ready 3 cycles after valid with rdata 0xA5A5_0001; `axi_grant_cnt`=2.
- CPU and AXI both valid in the same cycle after reset -> AXI served first, then CPU; `conflict_cnt`=1. Repeated simultaneous requests alternate grants.
- CPU write with wstrb 4'b0010, data 0x0000_7700, to a word preloaded 0x1122_3344 -> readback 0x1122_7744.
- AXI read of 0x0001_0000 (out of range, `MEM_AW`=12) -> `bram_en` never high; ready after 3 cycles; rdata 0.
- `RD_LAT`=3: CPU read -> ready exactly 5 cycles after valid; rdata matches BRAM model.
- Reset asserted during WAIT -> all outputs reach reset values asynchronously; after release, a fresh CPU read completes normally; counters 0 before it.
